fir_interp_dac: RTL and testbench

- Polyphase 1:L interpolating FIR on the DAC output path. It is the transmit-side counterpart of the receive-side ADC FIR low-pass.
- Accepts processed samples through a valid/ready handshake and emits L filtered, rounded, saturated DAC codes per input sample.
- Uses one time-multiplexed multiply-accumulate (MAC) unit and sits between the signal-processing core and the DAC driver.

---
 rtl/fir_pkg.sv | 31 +++
 rtl/fir_mac_unit.sv | 48 ++++
 rtl/fir_interp_dac.sv | 189 ++++++++++++++++++
 tb/tb_fir_interp_dac.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, state type and helpers for the DAC-path interpolating FIR
// and the MAC datapath it shares with the planned decimator.
package fir_pkg;

  localparam int unsigned TAPS_DEF = 16;

  // Symmetric low-pass prototype; polyphase branch p uses taps p, p+L, p+2L, ...
  localparam int COEF [0:TAPS_DEF-1] = '{
    311, 469, 917, 1582, 2352, 3091, 3671, 3990,
    3990, 3671, 3091, 2352, 1582, 917, 469, 311
  };

  // Sum of each polyphase branch (L = 4), i.e. the per-phase DC gain in coefficient units.
  localparam int PHASE_DC [0:3] = '{8235, 8148, 8148, 8235};

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } t_interp_state;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (longint unsigned x = 1; x < longint'(v); x = x << 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate slice: one product register feeding a clearable
// accumulator, so the multiplier and adder sit in separate pipeline stages.
module fir_mac_unit #(
  parameter int unsigned A_W   = 16,
  parameter int unsigned B_W   = 16,
  parameter int unsigned ACC_W = 34
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    add_i,
  input  logic signed [A_W-1:0]   a_i,
  input  logic signed [B_W-1:0]   b_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [A_W+B_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;

  always_comb begin
    prod_d = prod_q;
    if (en_i) begin
      prod_d = a_i * b_i;
    end

    // Clear takes priority so a new sum can start while the product stage loads.
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + ACC_W'(prod_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_interp_dac.sv
// Polyphase 1:L interpolating FIR for the DAC path: each accepted sample yields
// L rounded, saturated DAC codes computed on a single time-shared MAC.
module fir_interp_dac
  import fir_pkg::*;
#(
  parameter int unsigned TAPS       = 16,
  parameter int unsigned L          = 4,
  parameter int unsigned DIN_W      = 16,
  parameter int unsigned DOUT_W     = 14,
  parameter int unsigned COEF_W     = 16,
  parameter int unsigned SHIFT      = 13,
  parameter int unsigned OFFSET_BIN = 0
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic signed [DIN_W-1:0] din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [DOUT_W-1:0]       dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    sat
);

  localparam int unsigned N_M    = TAPS / L;
  localparam int unsigned PROD_W = DIN_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + clog2(N_M);
  localparam int unsigned CNT_W  = clog2(N_M + 2);
  localparam int unsigned P_W    = (L > 1) ? clog2(L) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_M + 1);
  localparam logic [P_W-1:0]   P_LAST   = P_W'(L - 1);

  localparam logic signed [ACC_W:0] HALF    = (ACC_W + 1)'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'((1 << (DOUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W + 1)'(-(1 << (DOUT_W - 1)));

  t_interp_state           state_q, state_d;
  logic [P_W-1:0]          p_q, p_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [DIN_W-1:0] hist_q [N_M];
  logic signed [DIN_W-1:0] hist_d [N_M];
  logic                    din_ready_q, din_ready_d;
  logic [DOUT_W-1:0]       dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    sat_q, sat_d;

  logic                     mac_clr, mac_en, mac_add;
  logic signed [DIN_W-1:0]  mac_a;
  logic signed [COEF_W-1:0] mac_b;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W:0]    rnd, shifted;
  logic [DOUT_W-1:0]        code;
  logic                     clip;

  fir_mac_unit #(
    .A_W   (DIN_W),
    .B_W   (COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk_i  (clk),
    .rst_ni (n_rst),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .add_i  (mac_add),
    .a_i    (mac_a),
    .b_i    (mac_b),
    .acc_o  (acc)
  );

  // Tap m of phase p pairs hist[m] with h[p + L*m]; cnt_q walks m.
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    for (int unsigned m = 0; m < N_M; m++) begin
      if (cnt_q == CNT_W'(m)) begin
        mac_a = hist_q[m];
        mac_b = COEF_W'(COEF[int'(p_q) + int'(L * m)]);
      end
    end
  end

  always_comb begin
    rnd     = (ACC_W + 1)'(acc) + HALF;
    shifted = rnd >>> SHIFT;
    clip    = 1'b0;
    code    = shifted[DOUT_W-1:0];
    if (shifted > SAT_MAX) begin
      code = {1'b0, {(DOUT_W - 1){1'b1}}};
      clip = 1'b1;
    end else if (shifted < SAT_MIN) begin
      code = {1'b1, {(DOUT_W - 1){1'b0}}};
      clip = 1'b1;
    end
    if (OFFSET_BIN != 0) begin
      code[DOUT_W-1] = ~code[DOUT_W-1];
    end
  end

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    cnt_d        = cnt_q;
    hist_d       = hist_q;
    din_ready_d  = din_ready_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    sat_d        = 1'b0;
    mac_clr      = 1'b0;
    mac_en       = 1'b0;
    mac_add      = 1'b0;

    case (state_q)
      IDLE: begin
        din_ready_d = 1'b1;
        if (din_valid && din_ready_q) begin
          for (int unsigned m = N_M - 1; m > 0; m--) begin
            hist_d[m] = hist_q[m-1];
          end
          hist_d[0]   = din;
          p_d         = '0;
          cnt_d       = '0;
          din_ready_d = 1'b0;
          state_d     = MAC;
        end
      end

      // cnt 0..N_M-1 loads products, 1..N_M accumulates, N_M+1 registers the code.
      MAC: begin
        mac_clr = (cnt_q == '0);
        mac_en  = (cnt_q < CNT_W'(N_M));
        mac_add = (cnt_q != '0) && (cnt_q <= CNT_W'(N_M));
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          dout_d       = code;
          dout_valid_d = 1'b1;
          sat_d        = clip;
          state_d      = OUT;
        end
      end

      OUT: begin
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          if (p_q == P_LAST) begin
            din_ready_d = 1'b1;
            state_d     = IDLE;
          end else begin
            p_d     = p_q + P_W'(1);
            cnt_d   = '0;
            state_d = MAC;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      p_q          <= '0;
      cnt_q        <= '0;
      din_ready_q  <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sat_q        <= 1'b0;
      for (int unsigned m = 0; m < N_M; m++) begin
        hist_q[m] <= '0;
      end
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      cnt_q        <= cnt_d;
      din_ready_q  <= din_ready_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sat_q        <= sat_d;
      hist_q       <= hist_d;
    end
  end

  assign din_ready  = din_ready_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_fir_interp_dac.sv
// Bench for fir_interp_dac: a two's-complement and an offset-binary instance share
// stimulus; outputs are compared with a direct polyphase convolution model.
module tb_fir_interp_dac;

  localparam int N_M = 4;
  localparam int L   = 4;

  logic               clk = 1'b0;
  logic               n_rst;
  logic signed [15:0] din;
  logic               din_valid;
  logic               dout_ready;
  logic               din_ready, din_ready_ob;
  logic [13:0]        dout, dout_ob;
  logic               dout_valid, dout_valid_ob;
  logic               sat, sat_ob;

  always #5 clk = ~clk;

  fir_interp_dac #(
    .TAPS(16), .L(4), .DIN_W(16), .DOUT_W(14), .COEF_W(16), .SHIFT(13), .OFFSET_BIN(0)
  ) dut (
    .clk(clk), .n_rst(n_rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .sat(sat)
  );

  fir_interp_dac #(
    .TAPS(16), .L(4), .DIN_W(16), .DOUT_W(14), .COEF_W(16), .SHIFT(13), .OFFSET_BIN(1)
  ) dut_ob (
    .clk(clk), .n_rst(n_rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_ob),
    .dout(dout_ob), .dout_valid(dout_valid_ob), .dout_ready(dout_ready), .sat(sat_ob)
  );

  int n_pass  = 0;
  int n_total = 0;

  int          hist_m [N_M];
  logic [13:0] got_code [L];
  logic [13:0] got_ob [L];
  logic        got_sat [L];
  logic        got_sat_ob [L];
  int          got_lat [L];
  bit          got_tmo, got_stall_bad, got_hs_bad, got_rdy_after;

  // ---------------- reference model ----------------
  function automatic longint model_r(input int p);
    longint acc;
    acc = 0;
    for (int m = 0; m < N_M; m++) begin
      acc += longint'(hist_m[m]) * longint'(fir_pkg::COEF[p + L * m]);
    end
    return (acc + 64'sd4096) >>> 13;
  endfunction

  function automatic logic [13:0] model_code(input int p, input bit ob);
    longint      r;
    logic [13:0] c;
    r = model_r(p);
    if (r > 8191)       c = 14'h1fff;
    else if (r < -8192) c = 14'h2000;
    else                c = 14'(r);
    if (ob) c[13] = ~c[13];
    return c;
  endfunction

  function automatic logic model_sat(input int p);
    longint r;
    r = model_r(p);
    return (r > 8191) || (r < -8192);
  endfunction

  task automatic model_push(input int x);
    for (int m = N_M - 1; m > 0; m--) hist_m[m] = hist_m[m-1];
    hist_m[0] = x;
  endtask

  task automatic model_clear();
    for (int m = 0; m < N_M; m++) hist_m[m] = 0;
  endtask

  // Drives one sample and captures its L outputs; stalls dout_ready in one phase if asked.
  task automatic send_sample(input int x, input int stall_phase, input int stall_len);
    int t;
    got_tmo = 0; got_stall_bad = 0; got_hs_bad = 0; got_rdy_after = 0;
    t = 0;
    while ((din_ready !== 1'b1 || din_ready_ob !== 1'b1) && t < 200) begin
      @(negedge clk); t++;
    end
    if (din_ready !== 1'b1) begin got_tmo = 1; return; end
    din = 16'(x);
    din_valid = 1'b1;
    model_push(x);
    t = 0;
    for (int p = 0; p < L; p++) begin
      if (p == stall_phase) dout_ready = 1'b0;
      while ((dout_valid !== 1'b1 || dout_valid_ob !== 1'b1) && t < 60) begin
        @(negedge clk); t++;
        if (p == 0 && t == 1) begin
          din_valid = 1'b0;
          if (din_ready !== 1'b0) got_hs_bad = 1;
        end
      end
      if (dout_valid !== 1'b1) begin
        got_tmo = 1; dout_ready = 1'b1; din_valid = 1'b0; return;
      end
      got_lat[p]    = t - 1;
      got_code[p]   = dout;
      got_ob[p]     = dout_ob;
      got_sat[p]    = sat;
      got_sat_ob[p] = sat_ob;
      if (p == stall_phase) begin
        for (int s = 0; s < stall_len; s++) begin
          din       = 16'($urandom);
          din_valid = s[0];
          @(negedge clk);
          if (dout_valid !== 1'b1 || dout !== got_code[p] || dout_ob !== got_ob[p] ||
              din_ready !== 1'b0 || sat !== 1'b0 || sat_ob !== 1'b0)
            got_stall_bad = 1;
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
      end
      @(negedge clk);
      t = 1;
      if (dout_valid !== 1'b0) got_hs_bad = 1;
      if (p == L - 1) got_rdy_after = (din_ready === 1'b1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int t;
    n_rst = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    n_total++; if (din_ready !== 1'b0) $display("FAIL reset_din_ready: got %b want 0", din_ready); else n_pass++;
    n_total++; if (dout_valid !== 1'b0) $display("FAIL reset_dout_valid: got %b want 0", dout_valid); else n_pass++;
    n_total++; if (dout !== 14'd0) $display("FAIL reset_dout: got %0d want 0", dout); else n_pass++;
    n_total++; if (sat !== 1'b0) $display("FAIL reset_sat: got %b want 0", sat); else n_pass++;
    n_rst = 1'b1;
    n_total++; if (din_ready !== 1'b0) $display("FAIL release_ready_early: got %b want 0", din_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (din_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", din_ready); else n_pass++;
    // get a held output on the wire, then pull reset mid-cycle
    din = 16'h1234; din_valid = 1'b1; dout_ready = 1'b0;
    @(negedge clk);
    din_valid = 1'b0;
    t = 0;
    while (dout_valid !== 1'b1 && t < 30) begin @(negedge clk); t++; end
    n_total++; if (dout_valid !== 1'b1 || dout === 14'd0) $display("FAIL reset_prep_output: valid %b dout %0d want valid 1 nonzero", dout_valid, dout); else n_pass++;
    @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    n_total++; if (dout_valid !== 1'b0) $display("FAIL async_dout_valid: got %b want 0", dout_valid); else n_pass++;
    n_total++; if (dout !== 14'd0) $display("FAIL async_dout: got %0d want 0", dout); else n_pass++;
    n_total++; if (din_ready !== 1'b0) $display("FAIL async_din_ready: got %b want 0", din_ready); else n_pass++;
    n_total++; if (sat !== 1'b0) $display("FAIL async_sat: got %b want 0", sat); else n_pass++;
    dout_ready = 1'b1;
    model_clear();
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    n_total++; if (din_ready !== 1'b1) $display("FAIL rerelease_ready: got %b want 1", din_ready); else n_pass++;
  endtask

  task automatic impulse_run(input string tag);
    logic [13:0] exp;
    for (int s = 0; s < 5; s++) begin
      send_sample((s == 0) ? 8192 : 0, -1, 0);
      n_total++; if (got_tmo) $display("FAIL %s_timeout[%0d]: got timeout want outputs", tag, s); else n_pass++;
      for (int p = 0; p < L; p++) begin
        exp = (s * L + p < 16) ? 14'(fir_pkg::COEF[s * L + p]) : 14'd0;
        n_total++; if (got_code[p] !== exp) $display("FAIL %s_code[%0d]: got %0d want %0d", tag, s * L + p, got_code[p], exp); else n_pass++;
        n_total++; if (got_ob[p] !== (exp ^ 14'h2000)) $display("FAIL %s_ob[%0d]: got %0d want %0d", tag, s * L + p, got_ob[p], exp ^ 14'h2000); else n_pass++;
        n_total++; if (got_lat[p] !== 6) $display("FAIL %s_latency[%0d]: got %0d want 6", tag, s * L + p, got_lat[p]); else n_pass++;
        n_total++; if (got_sat[p] !== 1'b0) $display("FAIL %s_sat[%0d]: got %b want 0", tag, s * L + p, got_sat[p]); else n_pass++;
      end
      n_total++; if (got_hs_bad || !got_rdy_after) $display("FAIL %s_handshake[%0d]: bad %b ready_after %b want 0/1", tag, s, got_hs_bad, got_rdy_after); else n_pass++;
    end
  endtask

  task automatic test_impulse();
    impulse_run("impulse");
  endtask

  task automatic test_dc();
    logic [13:0] exp;
    int dcv [L] = '{4118, 4074, 4074, 4118};
    for (int s = 0; s < 6; s++) begin
      send_sample(4096, -1, 0);
      n_total++; if (got_tmo) $display("FAIL dc_timeout[%0d]: got timeout want outputs", s); else n_pass++;
      for (int p = 0; p < L; p++) begin
        exp = (s >= N_M - 1) ? 14'(dcv[p]) : model_code(p, 0);
        n_total++; if (got_code[p] !== exp) $display("FAIL dc_code[%0d.%0d]: got %0d want %0d", s, p, got_code[p], exp); else n_pass++;
        exp = (s >= N_M - 1) ? 14'(dcv[p] + 8192) : model_code(p, 1);
        n_total++; if (got_ob[p] !== exp) $display("FAIL dc_ob[%0d.%0d]: got %0d want %0d", s, p, got_ob[p], exp); else n_pass++;
      end
    end
  endtask

  task automatic test_saturation();
    logic [13:0] exp;
    for (int s = 0; s < 10; s++) begin
      send_sample((s < 5) ? 32767 : -32768, -1, 0);
      n_total++; if (got_tmo) $display("FAIL sat_timeout[%0d]: got timeout want outputs", s); else n_pass++;
      for (int p = 0; p < L; p++) begin
        if (s == 3 || s == 4)      exp = 14'h1fff;
        else if (s == 8 || s == 9) exp = 14'h2000;
        else                       exp = model_code(p, 0);
        n_total++; if (got_code[p] !== exp) $display("FAIL sat_code[%0d.%0d]: got %0h want %0h", s, p, got_code[p], exp); else n_pass++;
        n_total++; if (got_ob[p] !== (exp ^ 14'h2000)) $display("FAIL sat_ob[%0d.%0d]: got %0h want %0h", s, p, got_ob[p], exp ^ 14'h2000); else n_pass++;
        n_total++; if (got_sat[p] !== ((s % 5 >= 3) ? 1'b1 : model_sat(p))) $display("FAIL sat_flag[%0d.%0d]: got %b want %b", s, p, got_sat[p], model_sat(p)); else n_pass++;
        n_total++; if (got_sat_ob[p] !== got_sat[p] || got_sat_ob[p] !== model_sat(p)) $display("FAIL sat_flag_ob[%0d.%0d]: got %b want %b", s, p, got_sat_ob[p], model_sat(p)); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic signed [15:0] r16;
    for (int s = 0; s < 3; s++) begin
      r16 = 16'($urandom);
      send_sample(int'(r16), (s == 1) ? 2 : -1, (s == 1) ? 10 : 0);
      n_total++; if (got_tmo) $display("FAIL bp_timeout[%0d]: got timeout want outputs", s); else n_pass++;
      for (int p = 0; p < L; p++) begin
        n_total++; if (got_code[p] !== model_code(p, 0)) $display("FAIL bp_code[%0d.%0d]: got %0d want %0d", s, p, got_code[p], model_code(p, 0)); else n_pass++;
        n_total++; if (got_lat[p] !== 6) $display("FAIL bp_latency[%0d.%0d]: got %0d want 6", s, p, got_lat[p]); else n_pass++;
      end
      n_total++; if (got_stall_bad) $display("FAIL bp_stall_stable[%0d]: got unstable want stable", s); else n_pass++;
      n_total++; if (got_hs_bad || !got_rdy_after) $display("FAIL bp_handshake[%0d]: bad %b ready_after %b want 0/1", s, got_hs_bad, got_rdy_after); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] r16;
    int t;
    for (int s = 0; s < 3; s++) begin
      r16 = 16'($urandom);
      send_sample(int'(r16), -1, 0);
      n_total++; if (got_code[0] !== model_code(0, 0)) $display("FAIL rmid_prefill[%0d]: got %0d want %0d", s, got_code[0], model_code(0, 0)); else n_pass++;
    end
    din = 16'sd8192; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    t = 0;
    while (dout_valid !== 1'b1 && t < 30) begin @(negedge clk); t++; end
    n_total++; if (dout_valid !== 1'b1) $display("FAIL rmid_phase0: got valid %b want 1", dout_valid); else n_pass++;
    repeat (2) @(negedge clk);
    n_total++; if (dout_valid !== 1'b0) $display("FAIL rmid_in_mac: got valid %b want 0", dout_valid); else n_pass++;
    n_rst = 1'b0;
    #1;
    n_total++; if (dout !== 14'd0 || din_ready !== 1'b0) $display("FAIL rmid_cleared: got dout %0d ready %b want 0/0", dout, din_ready); else n_pass++;
    model_clear();
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    impulse_run("rmid_impulse");
  endtask

  task automatic test_random();
    logic signed [15:0] r16;
    int sp;
    for (int s = 0; s < 10; s++) begin
      r16 = 16'($urandom);
      sp  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, L - 1)) : -1;
      send_sample(int'(r16), sp, int'($urandom_range(1, 5)));
      n_total++; if (got_tmo) $display("FAIL rnd_timeout[%0d]: got timeout want outputs", s); else n_pass++;
      for (int p = 0; p < L; p++) begin
        n_total++; if (got_code[p] !== model_code(p, 0)) $display("FAIL rnd_code[%0d.%0d]: got %0d want %0d", s, p, got_code[p], model_code(p, 0)); else n_pass++;
        n_total++; if (got_ob[p] !== model_code(p, 1)) $display("FAIL rnd_ob[%0d.%0d]: got %0d want %0d", s, p, got_ob[p], model_code(p, 1)); else n_pass++;
        n_total++; if (got_sat[p] !== model_sat(p)) $display("FAIL rnd_sat[%0d.%0d]: got %b want %b", s, p, got_sat[p], model_sat(p)); else n_pass++;
      end
      n_total++; if (got_stall_bad || got_hs_bad) $display("FAIL rnd_handshake[%0d]: stall %b hs %b want 0/0", s, got_stall_bad, got_hs_bad); else n_pass++;
    end
  endtask

  initial begin
    n_rst = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b1;
    test_reset();
    test_impulse();
    test_dc();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion want $finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
